// File: rtl/regfile_init.sv
// rtl/regfile_init.sv - LEGv8 register file: 2 async read ports, 1 write port, zero reg, optional bypass, index-sweep init
module regfile_init #(
    parameter int WIDTH     = 64,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 31,
    parameter int BYPASS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we3,
    input  logic [ADDR_BITS-1:0] ra1,
    input  logic [ADDR_BITS-1:0] ra2,
    input  logic [ADDR_BITS-1:0] wa3,
    input  logic [WIDTH-1:0]     wd3,
    output logic [WIDTH-1:0]     rd1,
    output logic [WIDTH-1:0]     rd2,
    output logic                 ready
);
    localparam int                   DEPTH     = 1 << ADDR_BITS;
    localparam bit                   ZERO_EN   = (ZERO_REG < DEPTH);
    localparam logic [ADDR_BITS-1:0] ZERO_ADDR = ADDR_BITS'(ZERO_REG);
    localparam logic [ADDR_BITS:0]   LAST_CNT  = (ADDR_BITS+1)'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS:0]   cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic [WIDTH-1:0]     mem_q [DEPTH];

    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_wa;
    logic [WIDTH-1:0]     mem_wd;
    logic [ADDR_BITS-1:0] sweep_addr;

    function automatic logic is_zero(input logic [ADDR_BITS-1:0] a);
        return ZERO_EN && (a == ZERO_ADDR);
    endfunction

    assign sweep_addr = cnt_q[ADDR_BITS-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        mem_we  = 1'b0;
        mem_wa  = wa3;
        mem_wd  = wd3;
        if (reset) begin
            state_d = INIT;
            cnt_d   = '0;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    // Sweep owns the write port; external writes are dropped, not queued.
                    mem_we = 1'b1;
                    mem_wa = sweep_addr;
                    mem_wd = is_zero(sweep_addr) ? '0 : WIDTH'(sweep_addr);
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end
                RUN: begin
                    mem_we = we3 && !is_zero(wa3);
                end
                default: begin
                    state_d = INIT;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ready_q <= ready_d;
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_BITS-1:0] ra);
        if (is_zero(ra)) begin
            return '0;
        end
        if ((BYPASS != 0) && ready_q && we3 && (wa3 == ra) && !is_zero(wa3)) begin
            return wd3;
        end
        return mem_q[ra];
    endfunction

    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

    assign ready = ready_q;
endmodule

// File: tb/tb_regfile_init.sv
// tb/tb_regfile_init.sv - directed self-checking bench for regfile_init with and without bypass
module tb_regfile_init;
    logic        clk = 1'b0;
    logic        reset;
    logic        we3;
    logic [4:0]  ra1, ra2, wa3;
    logic [63:0] wd3;
    logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        ready_b, ready_n;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] BEEF = 64'hDEAD_BEEF_0000_0001;

    regfile_init #(.WIDTH(64), .ADDR_BITS(5), .ZERO_REG(31), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .we3(we3), .ra1(ra1), .ra2(ra2), .wa3(wa3),
        .wd3(wd3), .rd1(rd1_b), .rd2(rd2_b), .ready(ready_b)
    );

    regfile_init #(.WIDTH(64), .ADDR_BITS(5), .ZERO_REG(31), .BYPASS(0)) u_nobyp (
        .clk(clk), .reset(reset), .we3(we3), .ra1(ra1), .ra2(ra2), .wa3(wa3),
        .wd3(wd3), .rd1(rd1_n), .rd2(rd2_n), .ready(ready_n)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input string tag);
        for (int i = 1; i <= 32; i++) begin
            if (i == 2) begin
                we3 = 1'b1; wa3 = 5'd3; wd3 = 64'd99;
            end
            step();
            if (i == 2) we3 = 1'b0;
            check({tag, "_ready_b"}, {63'd0, ready_b}, (i == 32) ? 64'd1 : 64'd0);
            check({tag, "_ready_n"}, {63'd0, ready_n}, (i == 32) ? 64'd1 : 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1; we3 = 1'b0; ra1 = 5'd31; ra2 = 5'd0; wa3 = 5'd0; wd3 = '0;

        // Reset edge E0
        step();
        check("rst_ready_b", {63'd0, ready_b}, 64'd0);
        check("rst_ready_n", {63'd0, ready_n}, 64'd0);
        check("rst_zero_b", rd1_b, 64'd0);
        check("rst_zero_n", rd1_n, 64'd0);

        // Init sweep with a write attempt at E2
        reset = 1'b0;
        sweep("init");
        ra1 = 5'd5; ra2 = 5'd30; #1;
        check("init_r5_b", rd1_b, 64'd5);
        check("init_r30_b", rd2_b, 64'd30);
        check("init_r5_n", rd1_n, 64'd5);
        check("init_r30_n", rd2_n, 64'd30);
        ra1 = 5'd31; ra2 = 5'd0; #1;
        check("init_r31_b", rd1_b, 64'd0);
        check("init_r0_b", rd2_b, 64'd0);
        ra1 = 5'd3; #1;
        check("init_wr_ignored_b", rd1_b, 64'd3);
        check("init_wr_ignored_n", rd1_n, 64'd3);

        // Write/read of reg 7
        we3 = 1'b1; wa3 = 5'd7; wd3 = BEEF; ra1 = 5'd7; ra2 = 5'd8; #1;
        check("wr7_same_b", rd1_b, BEEF);
        check("wr7_same_n", rd1_n, 64'd7);
        check("wr7_other_b", rd2_b, 64'd8);
        step();
        we3 = 1'b0; #1;
        check("wr7_after_b", rd1_b, BEEF);
        check("wr7_after_n", rd1_n, BEEF);

        // Zero register write is ignored
        we3 = 1'b1; wa3 = 5'd31; wd3 = 64'hFFFF_FFFF_FFFF_FFFF; ra1 = 5'd31; ra2 = 5'd6; #1;
        check("zero_same_b", rd1_b, 64'd0);
        check("zero_same_n", rd1_n, 64'd0);
        step();
        we3 = 1'b0; #1;
        check("zero_after_b", rd1_b, 64'd0);
        check("zero_after_n", rd1_n, 64'd0);
        check("zero_r6_b", rd2_b, 64'd6);
        ra2 = 5'd7; #1;
        check("zero_r7_b", rd2_b, BEEF);
        check("zero_r7_n", rd2_n, BEEF);

        // Dual-port forward
        we3 = 1'b1; wa3 = 5'd12; wd3 = 64'd77; ra1 = 5'd12; ra2 = 5'd12; #1;
        check("fwd_rd1_b", rd1_b, 64'd77);
        check("fwd_rd2_b", rd2_b, 64'd77);
        check("fwd_rd1_n", rd1_n, 64'd12);
        check("fwd_rd2_n", rd2_n, 64'd12);
        we3 = 1'b0; #1;
        check("nofwd_rd1_b", rd1_b, 64'd12);
        check("nofwd_rd2_b", rd2_b, 64'd12);

        // Write reg 10, then a held mid-op reset restarts the sweep
        we3 = 1'b1; wa3 = 5'd10; wd3 = 64'd1234; ra1 = 5'd10;
        step();
        we3 = 1'b0; #1;
        check("r10_written_b", rd1_b, 64'd1234);
        check("r10_written_n", rd1_n, 64'd1234);
        reset = 1'b1;
        step();
        step();
        step();
        check("held_ready_b", {63'd0, ready_b}, 64'd0);
        check("held_ready_n", {63'd0, ready_n}, 64'd0);
        reset = 1'b0;
        sweep("reinit");
        ra1 = 5'd10; ra2 = 5'd12; #1;
        check("reinit_r10_b", rd1_b, 64'd10);
        check("reinit_r10_n", rd1_n, 64'd10);
        check("reinit_r12_b", rd2_b, 64'd12);
        ra1 = 5'd7; #1;
        check("reinit_r7_n", rd1_n, 64'd7);

        // First accepted write right after ready
        we3 = 1'b1; wa3 = 5'd20; wd3 = 64'h55; ra1 = 5'd20;
        step();
        we3 = 1'b0; #1;
        check("first_wr_b", rd1_b, 64'h55);
        check("first_wr_n", rd1_n, 64'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
